vx_csr_sched: RTL

VX_CSR_SCHED -- requirements
Module: VX_csr_sched

---
 rtl/vx_csr_sched.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/vx_csr_sched.sv
`default_nettype none
// =============================================================================
// Module  : vx_csr_sched
// Brief   : Round-robin scheduler serialising CSR read / write / set / clear
//           requests onto a single CSR storage port, one operation in flight.
//           Define VX_CSR_SCHED_PERF_EN to add the perf_stalls counter.
// Revision: 1.0 - initial release
// =============================================================================
module vx_csr_sched #(
  parameter int NUM_REQS   = 4,
  parameter int XLEN       = 32,
  parameter int ADDR_BITS  = 12,
  parameter int NW_WIDTH   = 2,
  parameter int UUID_WIDTH = 1
`ifdef VX_CSR_SCHED_PERF_EN
  , parameter int PERF_CTR_BITS = 32
`endif
) (
  input  logic                                  clk,
  input  logic                                  reset_n,

  input  logic [NUM_REQS-1:0]                   req_valid,
  output logic [NUM_REQS-1:0]                   req_ready,
  input  logic [NUM_REQS-1:0][1:0]              req_op,
  input  logic [NUM_REQS-1:0][ADDR_BITS-1:0]    req_addr,
  input  logic [NUM_REQS-1:0][NW_WIDTH-1:0]     req_wid,
  input  logic [NUM_REQS-1:0][UUID_WIDTH-1:0]   req_uuid,
  input  logic [NUM_REQS-1:0][XLEN-1:0]         req_data,

  output logic [NUM_REQS-1:0]                   rsp_valid,
  input  logic [NUM_REQS-1:0]                   rsp_ready,
  output logic [XLEN-1:0]                       rsp_data,

  output logic                                  read_enable,
  output logic [ADDR_BITS-1:0]                  read_addr,
  output logic [NW_WIDTH-1:0]                   read_wid,
  output logic [UUID_WIDTH-1:0]                 read_uuid,
  input  logic [XLEN-1:0]                       read_data_ro,
  input  logic [XLEN-1:0]                       read_data_rw,

  output logic                                  write_enable,
  output logic [ADDR_BITS-1:0]                  write_addr,
  output logic [NW_WIDTH-1:0]                   write_wid,
  output logic [UUID_WIDTH-1:0]                 write_uuid,
  output logic [XLEN-1:0]                       write_data
`ifdef VX_CSR_SCHED_PERF_EN
  , output logic [PERF_CTR_BITS-1:0]            perf_stalls
`endif
);

  localparam int c_ptr_w = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  localparam logic [1:0] c_op_read  = 2'b00;
  localparam logic [1:0] c_op_write = 2'b01;
  localparam logic [1:0] c_op_set   = 2'b10;
  localparam logic [1:0] c_op_clear = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [c_ptr_w-1:0]      r_ptr;
  logic [c_ptr_w-1:0]      r_owner;
  logic [1:0]              r_op;
  logic [ADDR_BITS-1:0]    r_addr;
  logic [NW_WIDTH-1:0]     r_wid;
  logic [UUID_WIDTH-1:0]   r_uuid;
  logic [XLEN-1:0]         r_data;
  logic [XLEN-1:0]         r_old;

  logic                    w_found;
  logic [c_ptr_w-1:0]      w_winner;
  logic [c_ptr_w-1:0]      w_idx;
  logic                    w_skip_write;
  logic [c_ptr_w-1:0]      w_ptr_next;

  // Round-robin search starting at r_ptr; first valid requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_idx = c_ptr_w'((int'(r_ptr) + i) % NUM_REQS);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset_n && (r_state == S_IDLE) && w_found) begin
      req_ready[w_winner] = 1'b1;
    end
  end

  // Set/clear with an empty mask cannot change the CSR, so no write is issued.
  assign w_skip_write = (r_op == c_op_read) || (r_op[1] && (r_data == '0));
  assign w_ptr_next   = c_ptr_w'((int'(r_owner) + 1) % NUM_REQS);

  always_comb begin
    w_state_next = r_state;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    rsp_valid    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_next = S_READ;
        end
      end
      S_READ: begin
        read_enable  = 1'b1;
        w_state_next = w_skip_write ? S_RESP : S_WRITE;
      end
      S_WRITE: begin
        write_enable = 1'b1;
        w_state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid[r_owner] = 1'b1;
        if (rsp_ready[r_owner]) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (r_op)
      c_op_write: write_data = r_data;
      c_op_set:   write_data = r_old | r_data;
      c_op_clear: write_data = r_old & ~r_data;
      default:    write_data = r_data;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_op    <= '0;
      r_addr  <= '0;
      r_wid   <= '0;
      r_uuid  <= '0;
      r_data  <= '0;
      r_old   <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_IDLE) && w_found) begin
        r_owner <= w_winner;
        r_op    <= req_op[w_winner];
        r_addr  <= req_addr[w_winner];
        r_wid   <= req_wid[w_winner];
        r_uuid  <= req_uuid[w_winner];
        r_data  <= req_data[w_winner];
      end
      if (r_state == S_READ) begin
        r_old <= read_data_ro | read_data_rw;
      end
      if ((r_state == S_RESP) && rsp_ready[r_owner]) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  assign rsp_data   = r_old;
  assign read_addr  = r_addr;
  assign read_wid   = r_wid;
  assign read_uuid  = r_uuid;
  assign write_addr = r_addr;
  assign write_wid  = r_wid;
  assign write_uuid = r_uuid;

`ifdef VX_CSR_SCHED_PERF_EN
  logic [PERF_CTR_BITS-1:0] r_perf_stalls;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_stalls <= '0;
    end else if ((|req_valid) && !(|req_ready)) begin
      r_perf_stalls <= r_perf_stalls + PERF_CTR_BITS'(1);
    end
  end

  assign perf_stalls = r_perf_stalls;
`endif

endmodule
`default_nettype wire
